// File: rtl/core_fetch_pc.sv
// Program-counter / instruction-fetch stage.
// Holds the architectural PC, issues one instruction-memory request at a
// time, presents each returned word to decode with valid/ready, and turns
// branch-unit redirects into the next fetch address.
module core_fetch_pc #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  redirect_valid_i,
  input  logic                  redirect_rel_i,
  input  logic [DATA_WIDTH-1:0] redirect_val_i,
  input  logic [DATA_WIDTH-1:0] br_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic                  misalign_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_kill;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_instr_pc;
  logic                  r_instr_valid;
  logic                  r_misalign;

  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_target_mis;
  logic [DATA_WIDTH-1:0] w_pc_seq;

  // Resolve the redirect target (absolute or PC-relative, halfword bit cleared)
  always_comb begin
    w_sum        = redirect_rel_i ? (br_pc_i + redirect_val_i) : redirect_val_i;
    w_target     = w_sum & ~(DATA_WIDTH'(1));
    w_target_mis = w_target[1];
    w_pc_seq     = r_pc + DATA_WIDTH'(4);
  end

  // Output drive: request only in REQ, NOP whenever no instruction is valid
  always_comb begin
    imem_req_o    = (r_state == S_REQ);
    imem_addr_o   = r_pc;
    instr_valid_o = r_instr_valid;
    instr_o       = r_instr_valid ? r_instr : NOP_INSTR;
    instr_pc_o    = r_instr_pc;
    misalign_o    = r_misalign;
  end

  // Fetch FSM; a redirect always takes priority over the sequential update
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_kill        <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end

        S_REQ: begin
          if (redirect_valid_i) begin
            r_pc <= w_target;
            if (w_target_mis) begin
              r_state    <= S_ERR;
              r_misalign <= 1'b1;
              r_kill     <= 1'b0;
            end else if (imem_gnt_i) begin
              // request to the stale address already accepted: drop its data
              r_state <= S_WAIT;
              r_kill  <= 1'b1;
            end
          end else if (imem_gnt_i) begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_valid_i) begin
            r_pc <= w_target;
            if (w_target_mis) begin
              r_state    <= S_ERR;
              r_misalign <= 1'b1;
              r_kill     <= 1'b0;
            end else if (imem_rvalid_i) begin
              r_state <= S_REQ;
              r_kill  <= 1'b0;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (imem_rvalid_i) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_instr       <= imem_rdata_i;
              r_instr_pc    <= r_pc;
              r_pc          <= w_pc_seq;
              r_instr_valid <= 1'b1;
              r_state       <= S_VALID;
            end
          end
        end

        S_VALID: begin
          if (redirect_valid_i) begin
            r_pc          <= w_target;
            r_instr_valid <= 1'b0;
            if (w_target_mis) begin
              r_state    <= S_ERR;
              r_misalign <= 1'b1;
              r_kill     <= 1'b0;
            end else begin
              r_state <= S_REQ;
            end
          end else if (instr_ready_i) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end
        end

        S_ERR: begin
          r_instr_valid <= 1'b0;
          r_misalign    <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_fetch_pc.sv
// Directed bench for core_fetch_pc with RESET_PC = 0x100.
// Memory returns rdata = {16'hC0DE, addr[15:0]} for the address on the bus.
module tb_core_fetch_pc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        redirect_valid_i;
  logic        redirect_rel_i;
  logic [31:0] redirect_val_i;
  logic [31:0] br_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        misalign_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  core_fetch_pc #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0100),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_rel_i   (redirect_rel_i),
    .redirect_val_i   (redirect_val_i),
    .br_pc_i          (br_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .misalign_o       (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb imem_rdata_i = {16'hC0DE, imem_addr_o[15:0]};

  // advance one rising edge, then settle
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic redir(input logic rel, input logic [31:0] val, input logic [31:0] bpc);
    redirect_valid_i = 1'b1;
    redirect_rel_i   = rel;
    redirect_val_i   = val;
    br_pc_i          = bpc;
  endtask

  task automatic noredir();
    redirect_valid_i = 1'b0;
    redirect_rel_i   = 1'b0;
    redirect_val_i   = '0;
    br_pc_i          = '0;
  endtask

  // one full zero-latency fetch from REQ at addr, ending back in REQ at addr+4
  task automatic fetch_one(input string tag, input logic [31:0] addr);
    chk({tag, "_req"},  {31'd0, imem_req_o}, 32'd1);
    chk({tag, "_addr"}, imem_addr_o, addr);
    step();
    chk({tag, "_wait_req"}, {31'd0, imem_req_o}, 32'd0);
    step();
    chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
    chk({tag, "_instr"}, instr_o, {16'hC0DE, addr[15:0]});
    chk({tag, "_ipc"},   instr_pc_o, addr);
    step();
    chk({tag, "_next"},  imem_addr_o, addr + 32'd4);
    chk({tag, "_vdrop"}, {31'd0, instr_valid_o}, 32'd0);
  endtask

  initial begin
    rstn_i        = 1'b0;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b1;
    instr_ready_i = 1'b1;
    noredir();
    step();
    step();
    // reset state
    chk("rst_req",   {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr",  imem_addr_o, 32'h100);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_ipc",   instr_pc_o, 32'h100);
    chk("rst_mis",   {31'd0, misalign_o}, 32'd0);

    rstn_i = 1'b1;
    step();  // IDLE -> REQ
    fetch_one("f100", 32'h100);
    fetch_one("f104", 32'h104);

    // stall in VALID
    chk("s_req", {31'd0, imem_req_o}, 32'd1);
    chk("s_addr", imem_addr_o, 32'h108);
    step();  // WAIT
    instr_ready_i = 1'b0;
    step();  // VALID
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("stall_ipc",   instr_pc_o, 32'h108);
      chk("stall_instr", instr_o, 32'hC0DE0108);
      chk("stall_noreq", {31'd0, imem_req_o}, 32'd0);
      step();
    end
    chk("stall_held", {31'd0, instr_valid_o}, 32'd1);
    instr_ready_i = 1'b1;
    step();
    chk("stall_rel_req",  {31'd0, imem_req_o}, 32'd1);
    chk("stall_rel_addr", imem_addr_o, 32'h10C);

    // relative redirect in WAIT with rvalid the same cycle
    step();  // WAIT
    redir(1'b1, 32'h40, 32'h200);
    step();
    noredir();
    chk("relw_req",   {31'd0, imem_req_o}, 32'd1);
    chk("relw_addr",  imem_addr_o, 32'h240);
    chk("relw_valid", {31'd0, instr_valid_o}, 32'd0);

    // absolute redirect in WAIT before rvalid: kill the late response
    step();  // WAIT at 0x240
    imem_rvalid_i = 1'b0;
    redir(1'b0, 32'h300, 32'h0);
    step();
    noredir();
    chk("kill_req",   {31'd0, imem_req_o}, 32'd0);
    chk("kill_addr",  imem_addr_o, 32'h300);
    imem_rvalid_i = 1'b1;
    step();  // stale data dropped
    chk("kill_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("kill_req2",  {31'd0, imem_req_o}, 32'd1);
    chk("kill_addr2", imem_addr_o, 32'h300);

    // absolute redirect in VALID squashes; bit0 forced to 0
    step();  // WAIT
    step();  // VALID 0x300
    chk("sq_ipc", instr_pc_o, 32'h300);
    instr_ready_i = 1'b0;
    redir(1'b0, 32'h1235, 32'h0);
    step();
    noredir();
    instr_ready_i = 1'b1;
    chk("sq_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("sq_instr", instr_o, NOP);
    chk("sq_req",   {31'd0, imem_req_o}, 32'd1);
    chk("sq_addr",  imem_addr_o, 32'h1234);

    // redirect in REQ together with gnt: response is dropped
    redir(1'b0, 32'h2000, 32'h0);
    step();
    noredir();
    chk("rg_req",  {31'd0, imem_req_o}, 32'd0);
    chk("rg_addr", imem_addr_o, 32'h2000);
    step();
    chk("rg_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rg_req2",  {31'd0, imem_req_o}, 32'd1);
    chk("rg_addr2", imem_addr_o, 32'h2000);

    // redirect in REQ without gnt; relative add wraps modulo 2^32
    imem_gnt_i = 1'b0;
    redir(1'b1, 32'h20, 32'hFFFF_FFF0);
    step();
    chk("rn_req",  {31'd0, imem_req_o}, 32'd1);
    chk("rn_addr", imem_addr_o, 32'h10);
    redir(1'b0, 32'hFFFF_FFFC, 32'h0);
    step();
    noredir();
    chk("rn_addr2", imem_addr_o, 32'hFFFF_FFFC);
    imem_gnt_i = 1'b1;

    // sequential wrap
    fetch_one("wrap", 32'hFFFF_FFFC);
    chk("wrap_zero", imem_addr_o, 32'h0);

    // reset while in WAIT with rvalid arriving
    step();  // WAIT at 0x0
    rstn_i = 1'b0;
    step();
    chk("mrst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("mrst_req",   {31'd0, imem_req_o}, 32'd0);
    chk("mrst_addr",  imem_addr_o, 32'h100);
    chk("mrst_instr", instr_o, NOP);
    rstn_i = 1'b1;
    redir(1'b0, 32'h400, 32'h0);  // in IDLE: ignored
    step();
    noredir();
    chk("idle_req",  {31'd0, imem_req_o}, 32'd1);
    chk("idle_addr", imem_addr_o, 32'h100);
    chk("idle_valid", {31'd0, instr_valid_o}, 32'd0);

    // misaligned redirect -> sticky ERR
    imem_gnt_i = 1'b0;
    redir(1'b0, 32'h302, 32'h0);
    step();
    noredir();
    imem_gnt_i = 1'b1;
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_req",  {31'd0, imem_req_o}, 32'd0);
    chk("mis_addr", imem_addr_o, 32'h302);
    redir(1'b0, 32'h400, 32'h0);
    step();
    noredir();
    for (int i = 0; i < 4; i++) begin
      chk("err_flag",  {31'd0, misalign_o}, 32'd1);
      chk("err_req",   {31'd0, imem_req_o}, 32'd0);
      chk("err_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("err_addr",  imem_addr_o, 32'h302);
      step();
    end
    rstn_i = 1'b0;
    step();
    chk("err_rst_flag", {31'd0, misalign_o}, 32'd0);
    chk("err_rst_addr", imem_addr_o, 32'h100);
    rstn_i = 1'b1;
    step();
    fetch_one("restart", 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_fetch_pc.md
Name: core_fetch_pc

Overview:
- Program-counter and instruction-fetch stage. It sits directly downstream of the branch unit and upstream of decode.
- Holds the architectural PC and issues one instruction-memory request at a time. Each returned word is presented to decode with a valid/ready handshake.
- Consumes the branch unit's redirect: an absolute target for jumps, or a PC-relative offset for conditional branches. It resolves this into the next fetch address.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DATA_WIDTH, 32, width of PC, addresses, instructions and redirect value.
- NOP_INSTR, 32'h0000_0013, value driven on instr_o while nothing valid (ADDI x0,x0,0).

Ports:
- clk_i  in  1  core clock, all state on rising edge.
- rstn_i  in  1  reset, synchronous, active-low.
- redirect_valid_i  in  1  single-cycle pulse: branch unit has a resolved next-PC.
- redirect_rel_i  in  1  1: redirect_val_i is an offset added to br_pc_i (conditional branch); 0: absolute target (jump).
- redirect_val_i  in  DATA_WIDTH  branch unit new-PC output.
- br_pc_i  in  DATA_WIDTH  PC of the branching instruction.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  DATA_WIDTH  fetch address (= current PC).
- imem_gnt_i  in  1  request accepted.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  DATA_WIDTH  fetched instruction.
- instr_valid_o  out  1  instruction available to decode.
- instr_ready_i  in  1  decode accepts instruction.
- instr_o  out  DATA_WIDTH  instruction word.
- instr_pc_o  out  DATA_WIDTH  address of instr_o.
- misalign_o  out  1  sticky: redirect target not word-aligned; fetch halted.

Behaviour:
- Reset (rstn_i low at a clock edge) values:
  - pc=RESET_PC, state=IDLE, kill=0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - instr_valid_o=0, instr_o=NOP_INSTR, instr_pc_o=RESET_PC.
  - misalign_o=0.
- Reset mid-operation: takes effect at the next edge regardless of state. A late imem_rvalid_i after reset is ignored because rvalid is sampled only in WAIT.
- Target resolution:
  - target = redirect_rel_i ? br_pc_i + redirect_val_i : redirect_val_i with bit0 forced to 0.
  - Addition is modulo 2^DATA_WIDTH.
  - If target[1]=1, the redirect is misaligned.
- Sequential PC: pc+4 modulo 2^DATA_WIDTH, so 0xFFFF_FFFC wraps to 0x0000_0000.
- FSM states: IDLE, REQ, WAIT, VALID, ERR.
  - IDLE: entered only from reset. Unconditionally goes to REQ on the next cycle.
  - REQ:
    - imem_req_o=1, imem_addr_o=pc.
    - On gnt: go to WAIT.
    - Address is held stable until gnt unless a redirect occurs.
  - WAIT:
    - imem_req_o=0.
    - On rvalid with kill=0: instr_o<=rdata, instr_pc_o<=pc, pc<=pc+4, instr_valid_o<=1, go to VALID.
    - On rvalid with kill=1: discard data, kill<=0, go to REQ.
  - VALID:
    - instr_valid_o, instr_o and instr_pc_o are held until instr_ready_i.
    - On handshake: instr_valid_o<=0, go to REQ.
    - Minimum 3 cycles per instruction with zero-latency gnt/rvalid.
  - ERR: imem_req_o=0, instr_valid_o=0, misalign_o=1. Exit only by reset.
- Aligned redirect, by state (pc<=target in every case):
  - IDLE: the redirect is ignored.
  - REQ without gnt: stay in REQ. The new address appears on imem_addr_o the next cycle.
  - REQ with gnt in the same cycle: go to WAIT with kill<=1.
  - WAIT without rvalid: kill<=1.
  - WAIT with rvalid in the same cycle: data discarded, go to REQ.
  - VALID: instr_valid_o<=0 (instruction squashed unless instr_ready_i was high the same cycle, in which case it counts as consumed), go to REQ.
  - Redirect always overrides the sequential pc+4 update.
- Misaligned redirect in any state except IDLE:
  - Go to ERR, misalign_o<=1, instr_valid_o<=0.
  - pc<=target, for debug visibility.
  - Any outstanding response is ignored.
- redirect_valid_i while in ERR is ignored.

Test Plan:
- Release reset with RESET_PC=0x100, gnt and rvalid same-cycle, ready=1 → fetch addresses 0x100, 0x104, 0x108. instr_pc_o matches each. One instruction every 3 cycles.
- Hold instr_ready_i=0 for 5 cycles in VALID → instr_o and instr_pc_o stable, no new imem_req_o. Ready=1 → request to pc+4 on the following cycle.
- Conditional redirect in WAIT: br_pc_i=0x200, offset=0x40, rel=1 → pending rvalid data dropped, next imem_addr_o=0x240, instr_valid_o never pulses for the dropped word.
- Absolute redirect in VALID, redirect_val_i=0x0000_1235, rel=0 → current instruction squashed, next fetch 0x1234.
- Redirect with redirect_val_i=0x0000_0302, rel=0 → misalign_o=1 sticky, imem_req_o=0 forever. Reset clears misalign_o and restarts fetch at RESET_PC.
- pc=0xFFFF_FFFC sequential fetch → next address 0x0000_0000. Assert rstn_i=0 while in WAIT, then rvalid arrives → data ignored, fetch restarts at RESET_PC.
